// File: rtl/logic_unit_pkg.sv
// Shared types and defaults for the sliced logic unit.
// Flag accumulation is enabled by defining LOGIC_UNIT_FLAGS_EN.
package logic_unit_pkg;

   localparam int unsigned DEFAULT_SLICE = 4;

   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_XOR   = 3'b010,
      OP_NAND  = 3'b011,
      OP_NOR   = 3'b100,
      OP_XNOR  = 3'b101,
      OP_NOT_A = 3'b110,
      OP_PASS  = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit logic operator, time-multiplexed by logic_unit_seq.
module logic_slice
   import logic_unit_pkg::*;
#(
   parameter int unsigned SLICE = DEFAULT_SLICE
) (
   input  logic [SLICE-1:0] a_s,
   input  logic [SLICE-1:0] b_s,
   input  op_t              op,
   output logic [SLICE-1:0] y_s
);

   always_comb begin
      y_s = '0;
      case (op)
         OP_AND:   y_s = a_s & b_s;
         OP_OR:    y_s = a_s | b_s;
         OP_XOR:   y_s = a_s ^ b_s;
         OP_NAND:  y_s = ~(a_s & b_s);
         OP_NOR:   y_s = ~(a_s | b_s);
         OP_XNOR:  y_s = ~(a_s ^ b_s);
         OP_NOT_A: y_s = ~a_s;
         OP_PASS:  y_s = a_s;
         default:  y_s = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-op bitwise logic unit, one SLICE per cycle, LSB slice first, valid/ready on both sides.
// Define LOGIC_UNIT_FLAGS_EN to build the zero/parity accumulators; otherwise those ports read 0.
module logic_unit_seq
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SLICE = DEFAULT_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             zero,
   output logic             parity
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   generate
      if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_cfg
         $error("logic_unit_seq: WIDTH must be a non-zero multiple of SLICE");
      end
   endgenerate

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   op_t              op_q;
   logic [IW-1:0]    idx;
   logic [SLICE-1:0] y_s;
   logic             accept;
   logic             last;

   assign accept = in_valid & in_ready;
   assign last   = (idx == LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)    state_nxt = ST_BUSY;
         ST_BUSY: if (last)      state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_IDLE) && !rst;
      out_valid = (state == ST_DONE);
      busy      = (state == ST_BUSY);
   end

   logic_slice #(.SLICE(SLICE)) u_slice (
      .a_s (a_q[idx*SLICE +: SLICE]),
      .b_s (b_q[idx*SLICE +: SLICE]),
      .op  (op_q),
      .y_s (y_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_AND;
         idx    <= '0;
         result <= '0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         op_q   <= op_t'(op);
         idx    <= '0;
         result <= '0;
      end else if (state == ST_BUSY) begin
         result[idx*SLICE +: SLICE] <= y_s;
         idx <= last ? '0 : idx + IW'(1);
      end
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   logic any_acc, par_acc, zero_q, parity_q;

   // Final flags fold in the last slice directly so they land with out_valid.
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         any_acc  <= 1'b0;
         par_acc  <= 1'b0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
      end else if (state == ST_BUSY) begin
         any_acc <= any_acc | (|y_s);
         par_acc <= par_acc ^ (^y_s);
         if (last) begin
            zero_q   <= ~(any_acc | (|y_s));
            parity_q <= par_acc ^ (^y_s);
         end
      end
   end

   assign zero   = zero_q;
   assign parity = parity_q;
`else
   assign zero   = 1'b0;
   assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq (8/4 main instance plus a 16/4 instance).
module tb_logic_unit_seq;

   localparam int W  = 8;
   localparam int S  = 4;
   localparam int NS = W / S;
`ifdef LOGIC_UNIT_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] r;
      logic         z;
      logic         p;
      int           acc;
      bit           seen;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, busy, zero, parity;
   logic [W-1:0] a, b, result;
   logic [2:0]   op;

   logic         in_valid16, in_ready16, out_valid16, out_ready16, busy16, zero16, parity16;
   logic [15:0]  a16, b16, result16;
   logic [2:0]   op16;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic_unit_seq #(.WIDTH(W), .SLICE(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy), .zero(zero), .parity(parity)
   );

   logic_unit_seq #(.WIDTH(16), .SLICE(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .busy(busy16), .zero(zero16), .parity(parity16)
   );

   function automatic void chk(string name, bit ok, logic [15:0] act, logic [15:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic logic [15:0] ref_op(logic [15:0] x, logic [15:0] y, logic [2:0] o);
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return x ^ y;
         3'd3: return ~(x & y);
         3'd4: return ~(x | y);
         3'd5: return ~(x ^ y);
         3'd6: return ~x;
         default: return x;
      endcase
   endfunction

   // Scoreboard monitor: compare every cycle the DUT presents a result, pop on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 1'b0, 16'(result), 16'h0);
         end else begin
            if (!q[0].seen) chk("latency", cyc == q[0].acc + NS, 16'(cyc - q[0].acc), 16'(NS));
            q[0].seen = 1'b1;
            chk("result", result === q[0].r, 16'(result), 16'(q[0].r));
            chk("flags", {zero, parity} === {q[0].z, q[0].p}, {14'h0, zero, parity}, {14'h0, q[0].z, q[0].p});
            chk("in_ready_in_done", in_ready === 1'b0, 16'(in_ready), 16'h0);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] xo);
      bit   acc = 1'b0;
      exp_t e;
      @(posedge clk); #1;
      a = xa; b = xb; op = xo; in_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.r    = W'(ref_op(16'(xa), 16'(xb), xo));
            e.z    = FLAGS && (e.r == '0);
            e.p    = FLAGS && (^e.r);
            e.acc  = cyc + 1;
            e.seen = 1'b0;
            q.push_back(e);
            acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      if (!acc) chk("accept_timeout", 1'b0, 16'h0, 16'h1);
   endtask

   task automatic wait_valid();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) chk("out_valid_timeout", 1'b0, 16'h0, 16'h1);
   endtask

   task automatic wait_done(input int d);
      wait_valid();
      repeat (d) @(posedge clk);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   initial begin
      int acc16;
      bit seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;

      repeat (2) begin
         @(negedge clk);
         chk("in_ready_during_rst", in_ready === 1'b0, 16'(in_ready), 16'h0);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {out_valid, busy, zero, parity} === 4'b0, {12'h0, out_valid, busy, zero, parity}, 16'h0);
      chk("reset_result", result === '0, 16'(result), 16'h0);
      chk("in_ready_after_rst", in_ready === 1'b1, 16'(in_ready), 16'h1);

      send(8'hF0, 8'h3C, 3'b000); wait_done(0);
      send(8'hAA, 8'hAA, 3'b010); wait_done(1);
      send(8'h0F, 8'hFF, 3'b110); wait_done(0);

      // Back-pressure: hold out_ready low in DONE while offering new operands.
      send(8'h5A, 8'hC3, 3'b101);
      wait_valid();
      repeat (5) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_pulse", {out_valid, in_ready} === 2'b01, {14'h0, out_valid, in_ready}, 16'h1);

      // Reset during BUSY discards the operation.
      send(8'h33, 8'h55, 3'b001);
      rst = 1'b1;
      q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_after_midop_rst", {busy, in_ready} === 2'b01, {14'h0, busy, in_ready}, 16'h1);
      repeat (NS + 3) begin
         @(negedge clk);
         chk("no_out_after_rst", out_valid === 1'b0, 16'(out_valid), 16'h0);
      end

      for (int n = 0; n < 40; n++) begin
         send(W'($urandom), W'($urandom), 3'($urandom));
         wait_done(int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // Wider configuration.
      @(posedge clk); #1;
      a16 = 16'h1200; b16 = 16'h0034; op16 = 3'b001; in_valid16 = 1'b1;
      @(negedge clk);
      chk("in_ready16", in_ready16 === 1'b1, 16'(in_ready16), 16'h1);
      acc16 = cyc + 1;
      @(posedge clk); #1 in_valid16 = 1'b0; a16 = '0; b16 = '0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid16;
      end
      chk("out_valid16", seen, 16'(seen), 16'h1);
      chk("latency16", cyc == acc16 + 4, 16'(cyc - acc16), 16'h4);
      chk("result16", result16 === 16'h1234, result16, 16'h1234);
      chk("flags16", {zero16, parity16} === {1'b0, FLAGS}, {14'h0, zero16, parity16}, {15'h0, FLAGS});
      @(posedge clk); #1 out_ready16 = 1'b1;
      @(posedge clk); #1 out_ready16 = 1'b0;

      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      chk("drain", q.size() == 0, 16'(q.size()), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
